digit_sequencer: RTL and testbench
==================================

DIGIT_SEQUENCER -- requirements
Module: digit_sequencer

Interface
REQ-001 Parameter NUM_DIGITS, default 6: number of displayed digit slots (2..8).
REQ-002 Parameter LOOKUP_LAT, default 1: cycles from lookup request to valid lookup result (1..3).
REQ-003 Parameter BLANK_CODE, default 10: lookup number used for a blank or invalid digit.
REQ-004 clk  in  1  sole clock; all logic is rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to refresh all slots; sampled every cycle.
REQ-007 digits  in  4*NUM_DIGITS  BCD values; slot k occupies bits [4k+3:4k].
REQ-008 lk_number  out  4  number presented to the shared digit lookup.
REQ-009 lk_x_block  out  6  x block presented to the lookup (slot*4).
REQ-010 lk_valid  out  1  high when lk_number/lk_x_block carry a live request.
REQ-011 lk_digit_index  in  6  lookup result, valid LOOKUP_LAT cycles after the request.
REQ-012 lk_color  in  6  lookup result, same timing as lk_digit_index.
REQ-013 rd_slot  in  3  slot selected for readout.
REQ-014 rd_digit_index / rd_color  out  6 each  committed results for rd_slot, combinational from the display bank.
REQ-015 busy  out  1  high from the cycle after an accepted start until done.
REQ-016 done  out  1  one-cycle pulse when a refresh commits.
REQ-017 overrun  out  1  sticky: start arrived while busy.

Function
REQ-018 States SHALL be IDLE, RUN and DRAIN; reset enters IDLE.
REQ-019 In IDLE, start SHALL snapshot digits into a shadow register, clear slot counter, and go to RUN.
REQ-020 In RUN, one request per cycle for slot 0..NUM_DIGITS-1: lk_valid=1, lk_number=snapshot value, lk_x_block=slot*4.
REQ-021 Snapshot values >9 SHALL be replaced by BLANK_CODE on lk_number.
REQ-022 After the last slot is issued, the FSM SHALL enter DRAIN for exactly LOOKUP_LAT cycles with lk_valid=0.
REQ-023 A LOOKUP_LAT-deep valid/slot pipeline SHALL write each result into the working bank at its slot index.
REQ-024 On the final DRAIN cycle, the working bank SHALL be copied to the display bank, done pulses, and the FSM returns to IDLE.
REQ-025 The display bank SHALL change only on commit; readers never see a partial refresh.
REQ-026 Timing: start at cycle 0 gives the slot-k request in cycle k+1 and done in cycle NUM_DIGITS+LOOKUP_LAT+1.
REQ-027 start while busy SHALL be ignored and SHALL set overrun; start in the done cycle is accepted.
REQ-028 Changes to digits during RUN/DRAIN SHALL NOT affect the current refresh.
REQ-029 rd_slot >= NUM_DIGITS SHALL read zeros.
REQ-030 lk_number and lk_x_block SHALL be 0 when lk_valid=0.

Reset
REQ-031 Reset SHALL clear state to IDLE, both banks, the snapshot, the pipeline, busy, done, lk_valid and overrun.
REQ-032 Reset mid-refresh SHALL discard the refresh with no commit and no done pulse.

Configuration
REQ-033 Macro DIGIT_SEQ_OVERRUN_EN: when defined, overrun behaves per REQ-027 and clears only on reset.
REQ-034 Without DIGIT_SEQ_OVERRUN_EN, overrun SHALL be tied to 0; ignoring start while busy is unchanged.

Structure
REQ-035 A shared package SHALL hold the state enum, BLANK_CODE default, the slot-to-x_block multiplier (4) and result widths (6).
REQ-036 One sub-module, digit_seq_lat_pipe, SHALL implement the LOOKUP_LAT valid/slot delay line.

Verification
REQ-037 digits=0x123456, start -> lk_number 6,5,4,3,2,1 on cycles 1..6; lk_x_block 0,4,..,20; done at cycle 8 (LOOKUP_LAT=1).
REQ-038 Slot 2=0xF -> lk_number=10 on cycle 3; rd_slot=2 returns the result for 10 after done.
REQ-039 Second start at cycle 3 -> ignored, overrun=1 with macro and 0 without; done still at cycle 8.
REQ-040 Reset asserted at cycle 4 -> no done; display bank stays all-zero; IDLE next cycle.
REQ-041 LOOKUP_LAT=3 with a lookup model of matching latency -> done at cycle 10; every slot captures its own result.
REQ-042 Change digits at cycle 2 -> the committed bank reflects the cycle-0 snapshot; rd values are stable until commit.

Source files
------------

// File: rtl/digit_sequencer_pkg.sv
// rtl/digit_sequencer_pkg.sv - shared types and constants for the digit sequencer
package digit_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    localparam int BLANK_CODE_DEF = 10;
    localparam int X_BLOCK_MULT   = 4;
    localparam int RES_W          = 6;
    localparam int SLOT_W         = 3;

    typedef struct packed {
        logic [RES_W-1:0] digit_index;
        logic [RES_W-1:0] color;
    } lk_result_t;

    function automatic logic [3:0] bcd_to_number(input logic [3:0] bcd, input logic [3:0] blank);
        return (bcd > 4'd9) ? blank : bcd;
    endfunction

endpackage

// File: rtl/digit_sequencer_if.sv
// rtl/digit_sequencer_if.sv - request/result bus to the shared digit lookup
interface digit_sequencer_if;
    import digit_sequencer_pkg::*;

    logic [3:0]       lk_number;
    logic [5:0]       lk_x_block;
    logic             lk_valid;
    logic [RES_W-1:0] lk_digit_index;
    logic [RES_W-1:0] lk_color;

    modport master (
        output lk_number, lk_x_block, lk_valid,
        input  lk_digit_index, lk_color
    );

    modport slave (
        input  lk_number, lk_x_block, lk_valid,
        output lk_digit_index, lk_color
    );

endinterface

// File: rtl/digit_seq_lat_pipe.sv
// rtl/digit_seq_lat_pipe.sv - LAT-deep valid/slot delay line aligning slot tags with lookup results
module digit_seq_lat_pipe
    import digit_sequencer_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [SLOT_W-1:0] in_slot,
    output logic              out_valid,
    output logic [SLOT_W-1:0] out_slot
);

    logic [LAT-1:0]    valid_q, valid_d;
    logic [SLOT_W-1:0] slot_q [LAT];
    logic [SLOT_W-1:0] slot_d [LAT];

    always_comb begin
        valid_d    = valid_q;
        slot_d     = slot_q;
        valid_d[0] = in_valid;
        slot_d[0]  = in_slot;
        for (int i = 1; i < LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            slot_d[i]  = slot_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < LAT; i++) slot_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_slot  = slot_q[LAT-1];

endmodule

// File: rtl/digit_sequencer.sv
// rtl/digit_sequencer.sv - refreshes a bank of digit slots through a shared lookup
// Optional DIGIT_SEQ_OVERRUN_EN enables the sticky overrun flag.
module digit_sequencer
    import digit_sequencer_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int LOOKUP_LAT = 1,
    parameter int BLANK_CODE = BLANK_CODE_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [2:0]              rd_slot,
    output logic [RES_W-1:0]        rd_digit_index,
    output logic [RES_W-1:0]        rd_color,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun,
    digit_sequencer_if.master       lk
);

    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [SLOT_W-1:0] LAST_DRAIN = SLOT_W'(LOOKUP_LAT - 1);

    seq_state_e              state_q, state_d;
    logic [SLOT_W-1:0]       cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic                    lk_valid_q, lk_valid_d;
    logic [3:0]              lk_number_q, lk_number_d;
    logic [5:0]              lk_x_block_q, lk_x_block_d;
    logic [SLOT_W-1:0]       lk_slot_q, lk_slot_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    overrun_q, overrun_d;
    lk_result_t              work_q [NUM_DIGITS];
    lk_result_t              work_d [NUM_DIGITS];
    lk_result_t              disp_q [NUM_DIGITS];
    lk_result_t              disp_d [NUM_DIGITS];

    logic                    commit;
    logic [SLOT_W-1:0]       issue_slot;
    logic [4*NUM_DIGITS-1:0] bcd_src;
    logic [3:0]              issue_bcd;
    logic                    pipe_valid;
    logic [SLOT_W-1:0]       pipe_slot;

    digit_seq_lat_pipe #(.LAT(LOOKUP_LAT)) u_lat_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (lk_valid_q),
        .in_slot   (lk_slot_q),
        .out_valid (pipe_valid),
        .out_slot  (pipe_slot)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        snap_d     = snap_q;
        lk_valid_d = 1'b0;
        issue_slot = '0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        commit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d     = digits;
                    cnt_d      = '0;
                    state_d    = ST_RUN;
                    lk_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_q == LAST_SLOT) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d      = cnt_q + SLOT_W'(1);
                    lk_valid_d = 1'b1;
                    issue_slot = cnt_q + SLOT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == LAST_DRAIN) begin
                    commit  = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SLOT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef DIGIT_SEQ_OVERRUN_EN
        overrun_d = overrun_q | (start && (state_q != ST_IDLE));
`else
        overrun_d = 1'b0;
`endif

        // The first request is issued straight from digits, the rest from the snapshot.
        bcd_src   = (state_q == ST_IDLE) ? digits : snap_q;
        issue_bcd = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (issue_slot == SLOT_W'(i)) issue_bcd = bcd_src[4*i +: 4];
        end
        lk_number_d  = lk_valid_d ? bcd_to_number(issue_bcd, 4'(BLANK_CODE)) : 4'd0;
        lk_x_block_d = lk_valid_d ? 6'(issue_slot) * 6'(X_BLOCK_MULT) : 6'd0;
        lk_slot_d    = issue_slot;

        // The final result lands in the same cycle as the commit, so copy the updated bank.
        work_d = work_q;
        if (pipe_valid) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (pipe_slot == SLOT_W'(i)) work_d[i] = '{lk.lk_digit_index, lk.lk_color};
            end
        end
        disp_d = commit ? work_d : disp_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            snap_q       <= '0;
            lk_valid_q   <= 1'b0;
            lk_number_q  <= '0;
            lk_x_block_q <= '0;
            lk_slot_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                work_q[i] <= '0;
                disp_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            snap_q       <= snap_d;
            lk_valid_q   <= lk_valid_d;
            lk_number_q  <= lk_number_d;
            lk_x_block_q <= lk_x_block_d;
            lk_slot_q    <= lk_slot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            work_q       <= work_d;
            disp_q       <= disp_d;
        end
    end

    always_comb begin
        rd_digit_index = '0;
        rd_color       = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (rd_slot == SLOT_W'(i)) begin
                rd_digit_index = disp_q[i].digit_index;
                rd_color       = disp_q[i].color;
            end
        end
    end

    assign lk.lk_valid   = lk_valid_q;
    assign lk.lk_number  = lk_number_q;
    assign lk.lk_x_block = lk_x_block_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_digit_sequencer.sv
// tb/tb_digit_sequencer.sv - self-checking bench for digit_sequencer (LOOKUP_LAT 1 and 3 instances)
module tb_digit_sequencer;

    localparam int N = 6;
`ifdef DIGIT_SEQ_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, sel;
    logic [23:0] digits;
    logic [2:0]  rd_slot;

    always #5 clk = ~clk;

    digit_sequencer_if a_if ();
    digit_sequencer_if b_if ();

    logic [5:0] a_rd_idx, a_rd_col, b_rd_idx, b_rd_col;
    logic       a_busy, a_done, a_ovr, b_busy, b_done, b_ovr;

    digit_sequencer #(.NUM_DIGITS(N), .LOOKUP_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .start(start & ~sel), .digits(digits), .rd_slot(rd_slot),
        .rd_digit_index(a_rd_idx), .rd_color(a_rd_col), .busy(a_busy), .done(a_done),
        .overrun(a_ovr), .lk(a_if.master)
    );

    digit_sequencer #(.NUM_DIGITS(N), .LOOKUP_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .start(start & sel), .digits(digits), .rd_slot(rd_slot),
        .rd_digit_index(b_rd_idx), .rd_color(b_rd_col), .busy(b_busy), .done(b_done),
        .overrun(b_ovr), .lk(b_if.master)
    );

    // Lookup table of the external renderer: distinct per number and per x block
    function automatic logic [5:0] lut_idx(input logic [3:0] num, input logic [5:0] xb);
        return 6'(num) * 6'd4 + 6'(xb / 4);
    endfunction
    function automatic logic [5:0] lut_col(input logic [3:0] num, input logic [5:0] xb);
        return 6'(xb) + 6'(num) + 6'd1;
    endfunction

    logic [5:0] b_pi [3];
    logic [5:0] b_pc [3];
    always @(posedge clk) begin
        a_if.lk_digit_index <= a_if.lk_valid ? lut_idx(a_if.lk_number, a_if.lk_x_block) : 6'h3F;
        a_if.lk_color       <= a_if.lk_valid ? lut_col(a_if.lk_number, a_if.lk_x_block) : 6'h3F;
        b_pi[0] <= b_if.lk_valid ? lut_idx(b_if.lk_number, b_if.lk_x_block) : 6'h3F;
        b_pc[0] <= b_if.lk_valid ? lut_col(b_if.lk_number, b_if.lk_x_block) : 6'h3F;
        b_pi[1] <= b_pi[0]; b_pc[1] <= b_pc[0];
        b_pi[2] <= b_pi[1]; b_pc[2] <= b_pc[1];
    end
    assign b_if.lk_digit_index = b_pi[2];
    assign b_if.lk_color       = b_pc[2];

    logic       c_valid, c_busy, c_done, c_ovr;
    logic [3:0] c_num;
    logic [5:0] c_xb, c_idx, c_col;
    assign c_valid = sel ? b_if.lk_valid   : a_if.lk_valid;
    assign c_num   = sel ? b_if.lk_number  : a_if.lk_number;
    assign c_xb    = sel ? b_if.lk_x_block : a_if.lk_x_block;
    assign c_busy  = sel ? b_busy   : a_busy;
    assign c_done  = sel ? b_done   : a_done;
    assign c_ovr   = sel ? b_ovr    : a_ovr;
    assign c_idx   = sel ? b_rd_idx : a_rd_idx;
    assign c_col   = sel ? b_rd_col : a_rd_col;

    int n_vec = 0;
    int n_err = 0;

    logic [5:0] m_idx [2][8];
    logic [5:0] m_col [2][8];
    bit         m_ovr [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slot k shows BCD nibble k, or 10 (blank) when it is not a decimal digit
    function automatic logic [23:0] expected_numbers(input logic [23:0] d);
        logic [23:0] r = '0;
        for (int k = 0; k < N; k++) begin
            int v = int'((d >> (4 * k)) & 24'hF);
            r[4*k +: 4] = 4'((v > 9) ? 10 : v);
        end
        return r;
    endfunction

    task automatic check_rd(input string tag);
        logic [5:0] ei, ec;
        ei = (rd_slot < 3'(N)) ? m_idx[sel][rd_slot] : 6'd0;
        ec = (rd_slot < 3'(N)) ? m_col[sel][rd_slot] : 6'd0;
        check({tag, "_rd_idx"}, c_idx, ei);
        check({tag, "_rd_col"}, c_col, ec);
    endtask

    // One full refresh on instance s; optional extra start, digits change and chained start at done
    task automatic refresh(input bit s, input logic [23:0] dig, input logic [23:0] expnum,
                           input int extra_cyc, input int chg_cyc, input bit started,
                           input bit chain, input logic [23:0] next_dig);
        int  lat = s ? 3 : 1;
        int  dc  = N + lat + 1;
        bit  vld;
        if (!started) begin
            @(posedge clk); #1;
            sel = s; start = 1'b1; digits = dig;
        end
        for (int c = 1; c <= dc; c++) begin
            @(posedge clk); #1;
            start   = (c == extra_cyc) || (c == dc && chain);
            rd_slot = 3'($urandom_range(0, 7));
            if (c == chg_cyc) digits = 24'($urandom);
            if (c == dc && chain) digits = next_dig;
            if (c == dc) begin
                for (int k = 0; k < N; k++) begin
                    m_idx[s][k] = lut_idx(expnum[4*k +: 4], 6'(4 * k));
                    m_col[s][k] = lut_col(expnum[4*k +: 4], 6'(4 * k));
                end
            end
            if (extra_cyc > 0 && c == extra_cyc + 1) m_ovr[s] = OVR_EN;
            @(negedge clk);
            vld = (c <= N);
            check("lk_valid", c_valid, vld);
            check("lk_number", c_num, vld ? 4'(expnum >> (4 * (c - 1))) : 4'd0);
            check("lk_x_block", c_xb, vld ? 6'(4 * (c - 1)) : 6'd0);
            check("done", c_done, c == dc);
            check("busy", c_busy, c <= N + lat);
            check("overrun", c_ovr, m_ovr[s]);
            check_rd("refresh");
        end
    endtask

    typedef struct {
        logic [23:0] dig;
        logic [23:0] expnum;
    } vec_t;
    vec_t tbl [5];

    initial begin
        tbl[0] = '{24'h123456, 24'h123456};
        tbl[1] = '{24'hABCDEF, 24'hAAAAAA};
        tbl[2] = '{24'h909090, 24'h909090};
        tbl[3] = '{24'h000000, 24'h000000};
        tbl[4] = '{24'h123F56, 24'h123A56};

        for (int s = 0; s < 2; s++) begin
            m_ovr[s] = 1'b0;
            for (int k = 0; k < 8; k++) begin
                m_idx[s][k] = '0;
                m_col[s][k] = '0;
            end
        end

        reset = 1'b1; start = 1'b0; sel = 1'b0; digits = '0; rd_slot = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_lk_valid", a_if.lk_valid, 1'b0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_done", a_done, 1'b0);
        check("rst_overrun", a_ovr, 1'b0);
        for (int k = 0; k < 8; k++) begin
            rd_slot = 3'(k);
            #1 check_rd("rst");
        end

        // Reset in the middle of a refresh: no done, bank untouched, idle right after
        @(posedge clk); #1 start = 1'b1; digits = 24'h654321;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_lk_valid", a_if.lk_valid, 1'b0);
        check("mid_rst_busy", a_busy, 1'b0);
        repeat (10) begin
            @(negedge clk);
            check("mid_rst_done", a_done, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            rd_slot = 3'(k);
            #1 check_rd("mid_rst");
        end

        // Table, each next start issued in the previous done cycle
        for (int i = 0; i < 5; i++)
            refresh(1'b0, tbl[i].dig, tbl[i].expnum, 0, 0, i > 0, i < 4, (i < 4) ? tbl[(i < 4) ? i + 1 : i].dig : 24'h0);
        rd_slot = 3'd2;
        #1 check("blank_slot2_idx", a_rd_idx, lut_idx(4'd10, 6'd8));
        rd_slot = 3'd6;
        #1 check("slot6_zero", a_rd_idx, 6'd0);

        refresh(1'b0, 24'h987654, 24'h987654, 0, 2, 1'b0, 1'b0, 24'h0);

        for (int i = 0; i < 8; i++) begin
            logic [23:0] d;
            d = 24'($urandom);
            refresh(1'b0, d, expected_numbers(d), 0, ($urandom_range(0, 1) == 1) ? 3 : 0, 1'b0, 1'b0, 24'h0);
        end

        refresh(1'b1, 24'h123456, 24'h123456, 0, 0, 1'b0, 1'b0, 24'h0);
        for (int i = 0; i < 2; i++) begin
            logic [23:0] d;
            d = 24'($urandom);
            refresh(1'b1, d, expected_numbers(d), 0, 2, 1'b0, 1'b0, 24'h0);
        end
        for (int k = 0; k < 8; k++) begin
            rd_slot = 3'(k);
            #1 check_rd("lat3");
        end

        sel = 1'b0;
        refresh(1'b0, 24'h0A5F31, expected_numbers(24'h0A5F31), 3, 0, 1'b0, 1'b0, 24'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("overrun_sticky", a_ovr, OVR_EN);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
